ccff_chain_loader: RTL and testbench

//  Bitstream writer for a configuration-flip-flop (CCFF) scan chain inside a

---
 rtl/ccff_chain_loader.sv | 207 ++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_chain_loader
//  Purpose  : Bitstream writer for a configuration-flip-flop (CCFF) scan
//             chain. Accepts parallel config words over a valid/ready
//             handshake and shifts them LSB-first into the chain head while
//             asserting the chain shift enable. With the optional readback
//             build the chain is then rotated once through its own tail,
//             returning every loaded word while leaving contents intact.
//
//  Build option : CCFF_READBACK_EN (define to add the READBACK state and the
//                 rd_data / rd_valid / rd_ready ports)
//
//  Ports
//    clk        in   1       system clock, rising edge
//    reset      in   1       synchronous active-high reset
//    cfg_start  in   1       pulse to begin a load (sampled only in IDLE)
//    wr_data    in   WORD_W  config word, bit 0 shifted first
//    wr_valid   in   1       wr_data valid
//    wr_ready   out  1       loader accepts a word this cycle
//    ccff_head  out  1       serial data into the chain head
//    ccff_en    out  1       chain shift enable
//    ccff_tail  in   1       serial data from the chain tail (readback only)
//    busy       out  1       high in every state except IDLE
//    done       out  1       one-cycle completion pulse
//    rd_data    out  WORD_W  readback word            (readback build)
//    rd_valid   out  1       readback word valid      (readback build)
//    rd_ready   in   1       consumer accepts rd_data (readback build)
//
//  Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
`endif
);

    localparam int c_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int c_IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CHAIN_LEN = c_CNT_W'(CHAIN_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(WORD_W - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOAD     = 3'd1;
    localparam logic [2:0] c_ST_SHIFT    = 3'd2;
    localparam logic [2:0] c_ST_DONE     = 3'd4;
`ifdef CCFF_READBACK_EN
    localparam logic [2:0] c_ST_READBACK = 3'd3;
`endif

    logic [2:0]          r_state,  w_state_nxt;
    logic [WORD_W-1:0]   r_shreg,  w_shreg_nxt;
    // Chain-wide bit counter; reused as the rotate counter during readback.
    logic [c_CNT_W-1:0]  r_bits,   w_bits_nxt;
    // Bit position within the current word.
    logic [c_IDX_W-1:0]  r_idx,    w_idx_nxt;
    logic [c_CNT_W-1:0]  w_bits_inc;
    logic                w_word_end;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0]   r_rd_acc,   w_rd_acc_nxt;
    logic [WORD_W-1:0]   r_rd_data,  w_rd_data_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;
`else
    // The tail is only consulted when readback is built in.
    wire                 w_unused_tail = ccff_tail;
`endif

    assign w_bits_inc = r_bits + c_CNT_W'(1);
    // A word ends after WORD_W bits, or early when the chain fills up
    // (upper bits of a final partial word are simply never shifted).
    assign w_word_end = (r_idx == c_LAST_IDX) || (w_bits_inc == c_CHAIN_LEN);

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bits_nxt  = r_bits;
        w_idx_nxt   = r_idx;
        wr_ready    = 1'b0;
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
`ifdef CCFF_READBACK_EN
        w_rd_acc_nxt   = r_rd_acc;
        w_rd_data_nxt  = r_rd_data;
        // A presented word stays valid until the consumer takes it.
        w_rd_valid_nxt = r_rd_valid && !rd_ready;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = c_ST_LOAD;
                    w_bits_nxt  = '0;
                    w_idx_nxt   = '0;
                end
            end
            c_ST_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_shreg_nxt = wr_data;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                ccff_en     = 1'b1;
                ccff_head   = r_shreg[0];
                w_shreg_nxt = r_shreg >> 1;
                w_bits_nxt  = w_bits_inc;
                w_idx_nxt   = r_idx + c_IDX_W'(1);
                if (w_word_end) begin
                    w_idx_nxt = '0;
                    if (w_bits_inc == c_CHAIN_LEN) begin
`ifdef CCFF_READBACK_EN
                        w_state_nxt  = c_ST_READBACK;
                        w_bits_nxt   = '0;
                        w_rd_acc_nxt = '0;
`else
                        w_state_nxt  = c_ST_DONE;
`endif
                    end else begin
                        w_state_nxt = c_ST_LOAD;
                    end
                end
            end
`ifdef CCFF_READBACK_EN
            c_ST_READBACK: begin
                if (r_bits != c_CHAIN_LEN) begin
                    // Stall the rotation while a word is waiting to be taken.
                    if (!(r_rd_valid && !rd_ready)) begin
                        ccff_en   = 1'b1;
                        ccff_head = ccff_tail;
                        w_rd_acc_nxt[r_idx] = ccff_tail;
                        w_bits_nxt = w_bits_inc;
                        w_idx_nxt  = r_idx + c_IDX_W'(1);
                        if (w_word_end) begin
                            w_rd_data_nxt  = w_rd_acc_nxt;
                            w_rd_valid_nxt = 1'b1;
                            w_rd_acc_nxt   = '0;
                            w_idx_nxt      = '0;
                        end
                    end
                end else if (!r_rd_valid || rd_ready) begin
                    // Rotation complete and the last word has been consumed.
                    w_state_nxt = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_shreg <= '0;
            r_bits  <= '0;
            r_idx   <= '0;
`ifdef CCFF_READBACK_EN
            r_rd_acc   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_bits  <= w_bits_nxt;
            r_idx   <= w_idx_nxt;
`ifdef CCFF_READBACK_EN
            r_rd_acc   <= w_rd_acc_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
`endif
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);

`ifdef CCFF_READBACK_EN
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccff_chain_loader
//  Purpose  : Directed self-checking bench for ccff_chain_loader with
//             WORD_W=8, CHAIN_LEN=20 and a 20-bit shift-register chain model.
//             Readback scenarios are compiled when CCFF_READBACK_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              cfg_start = 1'b0;
    logic [WORD_W-1:0] wr_data   = '0;
    logic              wr_valid  = 1'b0;
    logic              wr_ready;
    logic              ccff_head;
    logic              ccff_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic [WORD_W-1:0] rd_q[$];
`endif

    logic [CHAIN_LEN-1:0] chain = '0;
    int n_checks = 0;
    int n_pass   = 0;
    int en_cnt   = 0;
    int done_cnt = 0;
    int head_err = 0;

    ccff_chain_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_start(cfg_start),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .ccff_head(ccff_head),
        .ccff_en  (ccff_en),
        .ccff_tail(ccff_tail),
        .busy     (busy),
        .done     (done)
`ifdef CCFF_READBACK_EN
        ,
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready)
`endif
    );

    always #5 clk = ~clk;

    // Chain model: head enters at the top, tail leaves from bit 0.
    assign ccff_tail = chain[0];
    always @(posedge clk) begin
        if (ccff_en) begin
            chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
            en_cnt++;
        end
        if (done) done_cnt++;
`ifdef CCFF_READBACK_EN
        if (rd_valid && rd_ready && !reset) rd_q.push_back(rd_data);
`endif
    end

    always @(negedge clk) begin
        if (!ccff_en && ccff_head) head_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_head", ccff_head, 0);
        check("rst_en", ccff_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef CCFF_READBACK_EN
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
`endif
        reset = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_wr_ready", wr_ready, 1);
    endtask

    // Returns at the negedge inside the first shift cycle of the word
    // (or of the cycle after a poke of cfg_start, if requested).
    task automatic send_word(input logic [7:0] w, input int gap, input bit poke_start);
        int t = 0;
        while (!wr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("wr_ready_wait", wr_ready, 1);
        for (int g = 0; g < gap; g++) begin
            check("gap_wr_ready", wr_ready, 1);
            check("gap_en", ccff_en, 0);
            @(negedge clk);
        end
        wr_data  = w;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        if (poke_start) begin
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic load_three(input int gap, input bit poke);
        send_word(8'hA5, 0, poke);
        send_word(8'h3C, gap, 1'b0);
        send_word(8'h0F, gap, 1'b0);
    endtask

    initial begin
        int e0, d0;

        // Test 1: plain load of three words
        do_reset();
        e0 = en_cnt; d0 = done_cnt;
        start_load();
        load_three(0, 1'b0);
        wait_done();
        check("t1_en_cycles", en_cnt - e0, 20);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_chain", chain, 20'hF3CA5);

        // Test 2: 5-cycle wr_valid gaps between words
        e0 = en_cnt; d0 = done_cnt;
        start_load();
        load_three(5, 1'b0);
        wait_done();
        check("t2_en_cycles", en_cnt - e0, 20);
        check("t2_chain", chain, 20'hF3CA5);

        // Test 3: cfg_start while busy is ignored
        e0 = en_cnt; d0 = done_cnt;
        start_load();
        load_three(0, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("t3_en_cycles", en_cnt - e0, 20);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_idle", busy, 0);

        // Test 4: reset during the 3rd shift cycle
        e0 = en_cnt;
        start_load();
        send_word(8'h5A, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_wr_ready", wr_ready, 0);
        check("t4_head", ccff_head, 0);
        check("t4_en", ccff_en, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_en_cycles", en_cnt - e0, 3);
        reset = 1'b0;
        @(negedge clk);
        check("t4_stays_idle", busy, 0);

`ifdef CCFF_READBACK_EN
        // Test 5: readback returns loaded words and preserves the chain
        e0 = en_cnt;
        rd_q.delete();
        rd_ready = 1'b1;
        start_load();
        load_three(0, 1'b0);
        wait_done();
        check("t5_rd_count", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            check("t5_rd0", rd_q[0], 8'hA5);
            check("t5_rd1", rd_q[1], 8'h3C);
            check("t5_rd2", rd_q[2], 8'h0F);
        end
        check("t5_chain", chain, 20'hF3CA5);
        check("t5_en_cycles", en_cnt - e0, 40);

        // Test 6: consumer back-pressure on the first readback word
        begin
            int t = 0;
            e0 = en_cnt;
            rd_q.delete();
            rd_ready = 1'b0;
            start_load();
            load_three(0, 1'b0);
            while (!rd_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("t6_rd_valid", rd_valid, 1);
            for (int k = 0; k < 4; k++) begin
                check("t6_stall_en", ccff_en, 0);
                check("t6_hold_data", rd_data, 8'hA5);
                @(negedge clk);
            end
            rd_ready = 1'b1;
            wait_done();
            check("t6_rd_count", rd_q.size(), 3);
            if (rd_q.size() == 3) begin
                check("t6_rd0", rd_q[0], 8'hA5);
                check("t6_rd1", rd_q[1], 8'h3C);
                check("t6_rd2", rd_q[2], 8'h0F);
            end
            check("t6_chain", chain, 20'hF3CA5);
            check("t6_en_cycles", en_cnt - e0, 40);
        end
`endif

        check("head_zero_when_idle", head_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
